// File: rtl/cpu_seq_ctrl_pkg.sv
// Shared types and constants for the CPU run/halt/step sequencer.
//   seq_state_t : sequencer state, also exported on the state_o debug port
//   opcode_t    : 6-bit instruction opcode field (insn[15:10])
//   OP_HALT     : opcode that stops execution; the CPU decodes it as a NOP
//   is_halt()   : true when a 16-bit instruction carries OP_HALT
package cpu_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    CLEAR  = 3'd2,
    RUN    = 3'd3,
    HALTED = 3'd4,
    STEP   = 3'd5
  } seq_state_t;

  typedef logic [5:0] opcode_t;

  localparam opcode_t OP_HALT = 6'h3F;

  function automatic logic is_halt(input logic [15:0] insn);
    return (insn[15:10] == OP_HALT);
  endfunction

endpackage

// File: rtl/cpu_seq_ctrl_if.sv
// Bundle of the loader link, instruction-memory port and CPU control lines
// handled by the sequencer.
//   loader : ld_valid, ld_data, ld_last in; ld_ready out
//   cpu    : pc_addr, insn in; cpu_en, cpu_rst_n out
//   imem   : mem_addr, mem_wdata, mem_we out
// master = sequencer side, slave = board / datapath side.
interface cpu_seq_ctrl_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
);
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;
  logic              ld_ready;
  logic [ADDR_W-1:0] pc_addr;
  logic [DATA_W-1:0] insn;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              cpu_en;
  logic              cpu_rst_n;

  modport master (
    input  ld_valid, ld_data, ld_last, pc_addr, insn,
    output ld_ready, mem_addr, mem_wdata, mem_we, cpu_en, cpu_rst_n
  );

  modport slave (
    output ld_valid, ld_data, ld_last, pc_addr, insn,
    input  ld_ready, mem_addr, mem_wdata, mem_we, cpu_en, cpu_rst_n
  );
endinterface

// File: rtl/cpu_seq_ctrl_imem_port_mux.sv
// Combinational select of the instruction-memory port between the program
// loader and CPU fetch. No registers: the memory sees the PC directly.
//   sel_load  in  : loader owns the port
//   we_req    in  : accepted loader word this cycle
//   wr_ptr    in  : loader write address
//   pc_addr   in  : CPU program counter
//   ld_data   in  : loader word
//   mem_addr  out : memory address
//   mem_wdata out : memory write data (zero when the CPU owns the port)
//   mem_we    out : memory write enable
module imem_port_mux #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic              sel_load,
  input  logic              we_req,
  input  logic [ADDR_W-1:0] wr_ptr,
  input  logic [ADDR_W-1:0] pc_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we
);
  assign mem_addr  = sel_load ? wr_ptr  : pc_addr;
  assign mem_wdata = sel_load ? ld_data : '0;
  assign mem_we    = sel_load & we_req;
endmodule

// File: rtl/cpu_seq_ctrl.sv
// Run/halt/step sequencer and instruction-memory arbiter for the 16-bit
// single-cycle CPU. Streams a program into instruction memory, clears the
// datapath, then gates CPU progress with cpu_en.
//   clk, rst_n       : clock, asynchronous active-low reset
//   load_req         : start a program load
//   run_req          : free-running execution
//   step_req         : execute exactly one instruction
//   halt_req         : stop execution / abort a load
//   bus (master)     : loader link, inst-mem port, PC/insn, cpu_en, cpu_rst_n
//   state_o          : current sequencer state
//   ld_count         : words written by the last load
//   load_err         : last load filled memory without seeing ld_last
//   cyc_cnt          : saturating count of cycles with cpu_en=1
module cpu_seq_ctrl
  import cpu_seq_ctrl_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_req,
  input  logic             run_req,
  input  logic             step_req,
  input  logic             halt_req,
  cpu_seq_ctrl_if.master   bus,
  output logic [2:0]       state_o,
  output logic [ADDR_W:0]  ld_count,
  output logic             load_err,
  output logic [CNT_W-1:0] cyc_cnt
);

  localparam logic [ADDR_W-1:0] PTR_LAST = '1;

  seq_state_t        state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr;
  logic              in_load;
  logic              xfer;
  logic              halt_hit;
  logic              cpu_en;

  assign in_load  = (state_q == LOAD);
  assign halt_hit = is_halt(bus.insn);
  // halt_req wins over a valid loader word: nothing is written that cycle.
  assign xfer     = in_load & bus.ld_valid & ~halt_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    cpu_en  = 1'b0;
    case (state_q)
      IDLE, HALTED: begin
        if (load_req)      state_d = LOAD;
        else if (step_req) state_d = STEP;
        else if (run_req)  state_d = RUN;
      end
      LOAD: begin
        if (halt_req)                                   state_d = IDLE;
        else if (xfer && (bus.ld_last || wr_ptr == PTR_LAST)) state_d = CLEAR;
      end
      CLEAR: state_d = HALTED;
      RUN: begin
        // A HALT instruction never retires, so the PC stays parked on it.
        cpu_en = ~halt_hit;
        if (halt_req || halt_hit) state_d = HALTED;
      end
      STEP: begin
        cpu_en  = ~halt_hit;
        state_d = HALTED;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      ld_count <= '0;
      load_err <= 1'b0;
    end else if (!in_load && state_d == LOAD) begin
      wr_ptr   <= '0;
      ld_count <= '0;
      load_err <= 1'b0;
    end else if (xfer) begin
      ld_count <= ld_count + (ADDR_W+1)'(1);
      // The pointer never wraps: the final slot ends the load either way.
      if (wr_ptr == PTR_LAST) begin
        if (!bus.ld_last) load_err <= 1'b1;
      end else begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       cyc_cnt <= '0;
    else if (cpu_en && cyc_cnt != '1) cyc_cnt <= cyc_cnt + CNT_W'(1);
  end

  assign bus.cpu_en    = cpu_en;
  assign bus.ld_ready  = in_load;
  assign bus.cpu_rst_n = rst_n & (state_q != CLEAR);
  assign state_o       = state_q;

  imem_port_mux #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_imem_port_mux (
    .sel_load  (in_load),
    .we_req    (xfer),
    .wr_ptr    (wr_ptr),
    .pc_addr   (bus.pc_addr),
    .ld_data   (bus.ld_data),
    .mem_addr  (bus.mem_addr),
    .mem_wdata (bus.mem_wdata),
    .mem_we    (bus.mem_we)
  );

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Bench for cpu_seq_ctrl: a behavioural instruction memory and a minimal
// PC model hang off the bus; expectations come from plain arithmetic on the
// program being loaded and the number of enabled cycles.
module tb_cpu_seq_ctrl;
  import cpu_seq_ctrl_pkg::*;

  localparam int ADDR_W  = 10;
  localparam int DATA_W  = 16;
  localparam int CNT_W   = 4;
  localparam int MEM_N   = 1 << ADDR_W;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             load_req, run_req, step_req, halt_req;
  logic [2:0]       state_o;
  logic [ADDR_W:0]  ld_count;
  logic             load_err;
  logic [CNT_W-1:0] cyc_cnt;

  cpu_seq_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  cpu_seq_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_req (load_req),
    .run_req  (run_req),
    .step_req (step_req),
    .halt_req (halt_req),
    .bus      (bus),
    .state_o  (state_o),
    .ld_count (ld_count),
    .load_err (load_err),
    .cyc_cnt  (cyc_cnt)
  );

  always #5 clk = ~clk;

  // Board-side memory and a CPU that only advances its PC.
  logic [DATA_W-1:0] tb_mem [MEM_N] = '{default: '0};
  logic [ADDR_W-1:0] pc = '0;
  int                wr_total = 0;

  assign bus.pc_addr = pc;
  assign bus.insn    = tb_mem[pc];

  always @(posedge clk) begin
    if (bus.mem_we) begin
      tb_mem[bus.mem_addr] <= bus.mem_wdata;
      wr_total             <= wr_total + 1;
    end
    if (!bus.cpu_rst_n)   pc <= '0;
    else if (bus.cpu_en)  pc <= pc + 1'b1;
  end

  logic [DATA_W-1:0] prog [MEM_N];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc_exp  = 0;

  function automatic int sat(input int x);
    return (x > CNT_MAX) ? CNT_MAX : x;
  endfunction

  task automatic fill_prog(input int n, input int halt_at);
    logic [DATA_W-1:0] w;
    for (int i = 0; i < n; i++) begin
      do w = DATA_W'($urandom); while (w[15:10] == OP_HALT);
      if (i == halt_at) w[15:10] = OP_HALT;
      prog[i] = w;
    end
  endtask

  // Loads prog[0..n-1]. gap_mode 0: back-to-back, 1: valid toggles, 2: random.
  // abort_at >= 0 raises halt_req with a valid word once abort_at words are in.
  task automatic do_load(input int n, input int gap_mode, input bit use_last, input int abort_at);
    int  i, cyc, w0;
    bit  v;
    i = 0; cyc = 0; w0 = wr_total;
    @(negedge clk); load_req = 1'b1;
    @(negedge clk); load_req = 1'b0;
    #1;
    n_checks++; if (ld_count !== '0) begin n_fail++; $display("FAIL load_entry_count: got %0d want 0", ld_count); end
    n_checks++; if (load_err !== 1'b0) begin n_fail++; $display("FAIL load_entry_err: got %0b want 0", load_err); end
    while (i < n && cyc < 4*n + 20) begin
      case (gap_mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      if (i == abort_at) begin v = 1'b1; halt_req = 1'b1; end
      bus.ld_valid = v;
      bus.ld_data  = prog[i];
      bus.ld_last  = use_last && (i == n-1);
      #1;
      n_checks++; if (state_o !== LOAD) begin n_fail++; $display("FAIL load_state: got %0d want %0d", state_o, LOAD); end
      n_checks++; if (bus.ld_ready !== 1'b1) begin n_fail++; $display("FAIL load_ready: got %0b want 1", bus.ld_ready); end
      n_checks++; if (bus.mem_we !== (v && i != abort_at)) begin n_fail++; $display("FAIL load_we: word %0d got %0b want %0b", i, bus.mem_we, v && i != abort_at); end
      if (v && i != abort_at) begin
        n_checks++; if (bus.mem_addr !== ADDR_W'(i)) begin n_fail++; $display("FAIL load_addr: got %0d want %0d", bus.mem_addr, i); end
        n_checks++; if (bus.mem_wdata !== prog[i]) begin n_fail++; $display("FAIL load_wdata: got %h want %h", bus.mem_wdata, prog[i]); end
      end
      if (i == abort_at) begin
        @(negedge clk); halt_req = 1'b0; bus.ld_valid = 1'b0;
        #1;
        n_checks++; if (state_o !== IDLE) begin n_fail++; $display("FAIL abort_state: got %0d want %0d", state_o, IDLE); end
        n_checks++; if (ld_count !== (ADDR_W+1)'(abort_at)) begin n_fail++; $display("FAIL abort_count: got %0d want %0d", ld_count, abort_at); end
        n_checks++; if (wr_total - w0 !== abort_at) begin n_fail++; $display("FAIL abort_writes: got %0d want %0d", wr_total - w0, abort_at); end
        return;
      end
      @(negedge clk);
      if (v) i++;
      cyc++;
    end
    bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
    #1;
    n_checks++; if (i != n) begin n_fail++; $display("FAIL load_timeout: got %0d words want %0d", i, n); end
    n_checks++; if (state_o !== CLEAR) begin n_fail++; $display("FAIL clear_state: got %0d want %0d", state_o, CLEAR); end
    n_checks++; if (bus.cpu_rst_n !== 1'b0) begin n_fail++; $display("FAIL clear_rst: got %0b want 0", bus.cpu_rst_n); end
    n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL clear_we: got %0b want 0", bus.mem_we); end
    @(negedge clk); #1;
    n_checks++; if (state_o !== HALTED) begin n_fail++; $display("FAIL post_load_state: got %0d want %0d", state_o, HALTED); end
    n_checks++; if (bus.cpu_rst_n !== 1'b1) begin n_fail++; $display("FAIL post_load_rst: got %0b want 1", bus.cpu_rst_n); end
    n_checks++; if (ld_count !== (ADDR_W+1)'(n)) begin n_fail++; $display("FAIL ld_count: got %0d want %0d", ld_count, n); end
    n_checks++; if (load_err !== !use_last) begin n_fail++; $display("FAIL load_err: got %0b want %0b", load_err, !use_last); end
    n_checks++; if (wr_total - w0 !== n) begin n_fail++; $display("FAIL load_writes: got %0d want %0d", wr_total - w0, n); end
    for (int k = 0; k < n; k++) begin
      n_checks++; if (tb_mem[k] !== prog[k]) begin n_fail++; $display("FAIL mem_content: addr %0d got %h want %h", k, tb_mem[k], prog[k]); end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load_req = 0; run_req = 0; step_req = 0; halt_req = 0;
    bus.ld_valid = 0; bus.ld_data = '0; bus.ld_last = 0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (state_o !== IDLE) begin n_fail++; $display("FAIL rst_state: got %0d want %0d", state_o, IDLE); end
    n_checks++; if (ld_count !== '0) begin n_fail++; $display("FAIL rst_count: got %0d want 0", ld_count); end
    n_checks++; if (load_err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %0b want 0", load_err); end
    n_checks++; if (cyc_cnt !== '0) begin n_fail++; $display("FAIL rst_cyc: got %0d want 0", cyc_cnt); end
    n_checks++; if (bus.cpu_en !== 1'b0) begin n_fail++; $display("FAIL rst_en: got %0b want 0", bus.cpu_en); end
    n_checks++; if (bus.ld_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %0b want 0", bus.ld_ready); end
    n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_we: got %0b want 0", bus.mem_we); end
    n_checks++; if (bus.cpu_rst_n !== 1'b0) begin n_fail++; $display("FAIL rst_cpu_rst: got %0b want 0", bus.cpu_rst_n); end
    rst_n = 1'b1;
    #1;
    n_checks++; if (bus.cpu_rst_n !== 1'b1) begin n_fail++; $display("FAIL rst_release: got %0b want 1", bus.cpu_rst_n); end
    cyc_exp = 0;
  endtask

  task automatic test_load_basic();
    prog[0] = 16'h1111; prog[1] = 16'h2222; prog[2] = 16'h3333; prog[3] = 16'h4444;
    do_load(4, 0, 1'b1, -1);
  endtask

  task automatic test_load_gaps();
    fill_prog(6, -1);
    do_load(6, 1, 1'b1, -1);
    fill_prog(7, -1);
    do_load(7, 2, 1'b1, -1);
  endtask

  task automatic test_step();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); step_req = 1'b1;
      #1;
      n_checks++; if (bus.cpu_en !== 1'b0) begin n_fail++; $display("FAIL step_pre_en: got %0b want 0", bus.cpu_en); end
      @(negedge clk); step_req = 1'b0; halt_req = (k == 1);
      #1;
      n_checks++; if (state_o !== STEP) begin n_fail++; $display("FAIL step_state: got %0d want %0d", state_o, STEP); end
      n_checks++; if (bus.cpu_en !== 1'b1) begin n_fail++; $display("FAIL step_en: got %0b want 1", bus.cpu_en); end
      cyc_exp++;
      @(negedge clk); halt_req = 1'b0;
      #1;
      n_checks++; if (state_o !== HALTED) begin n_fail++; $display("FAIL step_back: got %0d want %0d", state_o, HALTED); end
      n_checks++; if (bus.cpu_en !== 1'b0) begin n_fail++; $display("FAIL step_post_en: got %0b want 0", bus.cpu_en); end
    end
    n_checks++; if (cyc_cnt !== CNT_W'(sat(cyc_exp))) begin n_fail++; $display("FAIL step_cyc: got %0d want %0d", cyc_cnt, sat(cyc_exp)); end
    n_checks++; if (pc !== ADDR_W'(3)) begin n_fail++; $display("FAIL step_pc: got %0d want 3", pc); end
  endtask

  task automatic test_run_halt();
    int cyc0;
    fill_prog(8, 5);
    do_load(8, 0, 1'b1, -1);
    @(negedge clk); run_req = 1'b1;
    @(negedge clk); run_req = 1'b0;
    for (int k = 0; k <= 5; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      n_checks++; if (state_o !== RUN) begin n_fail++; $display("FAIL run_state: got %0d want %0d", state_o, RUN); end
      n_checks++; if (bus.cpu_en !== (k < 5)) begin n_fail++; $display("FAIL run_en: pc %0d got %0b want %0b", k, bus.cpu_en, k < 5); end
      if (k < 5) cyc_exp++;
    end
    @(negedge clk); #1;
    n_checks++; if (state_o !== HALTED) begin n_fail++; $display("FAIL halt_state: got %0d want %0d", state_o, HALTED); end
    n_checks++; if (pc !== ADDR_W'(5)) begin n_fail++; $display("FAIL halt_pc: got %0d want 5", pc); end
    n_checks++; if (cyc_cnt !== CNT_W'(sat(cyc_exp))) begin n_fail++; $display("FAIL halt_cyc: got %0d want %0d", cyc_cnt, sat(cyc_exp)); end
    cyc0 = cyc_exp;
    run_req = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); #1;
      n_checks++; if (bus.cpu_en !== 1'b0) begin n_fail++; $display("FAIL held_run_en: got %0b want 0", bus.cpu_en); end
    end
    run_req = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    n_checks++; if (state_o !== HALTED) begin n_fail++; $display("FAIL held_run_state: got %0d want %0d", state_o, HALTED); end
    n_checks++; if (pc !== ADDR_W'(5)) begin n_fail++; $display("FAIL held_run_pc: got %0d want 5", pc); end
    n_checks++; if (cyc_cnt !== CNT_W'(sat(cyc0))) begin n_fail++; $display("FAIL held_run_cyc: got %0d want %0d", cyc_cnt, sat(cyc0)); end
  endtask

  task automatic test_overflow();
    fill_prog(MEM_N, -1);
    do_load(MEM_N, 2, 1'b0, -1);
  endtask

  task automatic test_run_halt_req();
    int n;
    n = $urandom_range(10, 20);
    @(negedge clk); run_req = 1'b1;
    @(negedge clk); run_req = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      n_checks++; if (bus.cpu_en !== 1'b1) begin n_fail++; $display("FAIL run_free_en: got %0b want 1", bus.cpu_en); end
      cyc_exp++;
    end
    @(negedge clk); halt_req = 1'b1;
    #1;
    n_checks++; if (state_o !== RUN) begin n_fail++; $display("FAIL halt_req_state: got %0d want %0d", state_o, RUN); end
    cyc_exp++;
    @(negedge clk); halt_req = 1'b0;
    #1;
    n_checks++; if (state_o !== HALTED) begin n_fail++; $display("FAIL halt_req_stop: got %0d want %0d", state_o, HALTED); end
    n_checks++; if (pc !== ADDR_W'(n + 1)) begin n_fail++; $display("FAIL halt_req_pc: got %0d want %0d", pc, n + 1); end
    n_checks++; if (cyc_cnt !== CNT_W'(sat(cyc_exp))) begin n_fail++; $display("FAIL cyc_sat: got %0d want %0d", cyc_cnt, sat(cyc_exp)); end
  endtask

  task automatic test_abort_and_priority();
    fill_prog(6, -1);
    do_load(6, 0, 1'b1, 3);
    @(negedge clk); step_req = 1'b1; run_req = 1'b1;
    @(negedge clk); step_req = 1'b0; run_req = 1'b0;
    #1;
    n_checks++; if (state_o !== STEP) begin n_fail++; $display("FAIL idle_prio_state: got %0d want %0d", state_o, STEP); end
    cyc_exp++;
    @(negedge clk); #1;
    n_checks++; if (state_o !== HALTED) begin n_fail++; $display("FAIL idle_prio_back: got %0d want %0d", state_o, HALTED); end
    n_checks++; if (cyc_cnt !== CNT_W'(sat(cyc_exp))) begin n_fail++; $display("FAIL cyc_hold_sat: got %0d want %0d", cyc_cnt, sat(cyc_exp)); end
  endtask

  task automatic test_async_reset();
    // Mid-LOAD
    @(negedge clk); load_req = 1'b1;
    @(negedge clk); load_req = 1'b0; bus.ld_valid = 1'b1; bus.ld_data = 16'hBEEF;
    #1;
    n_checks++; if (bus.mem_we !== 1'b1) begin n_fail++; $display("FAIL midload_we: got %0b want 1", bus.mem_we); end
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL midload_rst_we: got %0b want 0", bus.mem_we); end
    n_checks++; if (state_o !== IDLE) begin n_fail++; $display("FAIL midload_rst_state: got %0d want %0d", state_o, IDLE); end
    n_checks++; if (bus.ld_ready !== 1'b0) begin n_fail++; $display("FAIL midload_rst_ready: got %0b want 0", bus.ld_ready); end
    n_checks++; if (cyc_cnt !== '0) begin n_fail++; $display("FAIL midload_rst_cyc: got %0d want 0", cyc_cnt); end
    n_checks++; if (ld_count !== '0) begin n_fail++; $display("FAIL midload_rst_count: got %0d want 0", ld_count); end
    bus.ld_valid = 1'b0;
    cyc_exp = 0;
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    // Mid-RUN
    @(negedge clk); run_req = 1'b1;
    @(negedge clk); run_req = 1'b0;
    #1;
    n_checks++; if (bus.cpu_en !== 1'b1) begin n_fail++; $display("FAIL midrun_en: got %0b want 1", bus.cpu_en); end
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (bus.cpu_en !== 1'b0) begin n_fail++; $display("FAIL midrun_rst_en: got %0b want 0", bus.cpu_en); end
    n_checks++; if (state_o !== IDLE) begin n_fail++; $display("FAIL midrun_rst_state: got %0d want %0d", state_o, IDLE); end
    n_checks++; if (bus.cpu_rst_n !== 1'b0) begin n_fail++; $display("FAIL midrun_rst_cpu: got %0b want 0", bus.cpu_rst_n); end
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    #1;
    n_checks++; if (cyc_cnt !== '0) begin n_fail++; $display("FAIL midrun_rst_cyc: got %0d want 0", cyc_cnt); end
    // load_req and run_req together in HALTED
    fill_prog(2, -1);
    do_load(2, 0, 1'b1, -1);
    @(negedge clk); load_req = 1'b1; run_req = 1'b1;
    @(negedge clk); load_req = 1'b0; run_req = 1'b0;
    #1;
    n_checks++; if (state_o !== LOAD) begin n_fail++; $display("FAIL halted_prio_state: got %0d want %0d", state_o, LOAD); end
    n_checks++; if (bus.cpu_en !== 1'b0) begin n_fail++; $display("FAIL halted_prio_en: got %0b want 0", bus.cpu_en); end
    @(negedge clk); halt_req = 1'b1;
    @(negedge clk); halt_req = 1'b0;
    #1;
    n_checks++; if (state_o !== IDLE) begin n_fail++; $display("FAIL final_abort_state: got %0d want %0d", state_o, IDLE); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_basic();
    test_load_gaps();
    test_step();
    test_run_halt();
    test_overflow();
    test_run_halt_req();
    test_abort_and_priority();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
